// File: rtl/btr_serial.sv
// -----------------------------------------------------------------------------
// btr_serial
//
// Multi-cycle bit-reverse coprocessor. It captures a 16-bit operand and a field
// length, then shifts the operand one bit per clock into an accumulator. The
// low `len` bits of the result come out in reverse order. Bits above the field
// pass through from the captured operand unchanged. Because the operation is
// its own inverse, it also undoes a previous field reverse.
//
// Configuration macro: BTR_SERIAL_FIELD_EN
//   defined     : `len` selects the field length. 0 or any value above 16
//                 means 16.
//   not defined : `len` is ignored. Every operation reverses the full word
//                 and takes WIDTH cycles.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request strobe, sampled only while idle
//   In     in   WIDTH  operand, captured on an accepted start
//   len    in   5      field length, captured on an accepted start
//   Out    out  WIDTH  result register; holds its value between operations
//   busy   out  1      high while shifting
//   done   out  1      one-cycle pulse in the cycle after Out is updated
// -----------------------------------------------------------------------------
module btr_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic [4:0]       len,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic             done
);

    localparam logic [4:0] FULL_LEN = 5'(WIDTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q,  hold_d;   // untouched copy, used for pass-through bits
    logic [WIDTH-1:0] src_q,   src_d;    // operand being consumed LSB first
    logic [WIDTH-1:0] acc_q,   acc_d;    // reversed bits collect here
    logic [4:0]       cnt_q,   cnt_d;    // shifts still to do
    logic [WIDTH-1:0] out_q,   out_d;
    logic             done_q,  done_d;

    logic [4:0]       eff_len;           // length the next operation will use
    logic [WIDTH-1:0] mask;              // ones over the reversed field
    logic [WIDTH-1:0] acc_shift;         // accumulator value after this cycle's shift

`ifdef BTR_SERIAL_FIELD_EN
    // The field length has to stay in effect for the whole operation, because
    // `len` may change after capture. So it is kept in its own register.
    logic [4:0] flen_q, flen_d;

    always_comb begin
        eff_len = len;
        if (len == 5'd0 || len > FULL_LEN) begin
            eff_len = FULL_LEN;
        end
    end

    always_comb begin
        flen_d = flen_q;
        if (state_q == S_IDLE && start) begin
            flen_d = eff_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flen_q <= '0;
        end else begin
            flen_q <= flen_d;
        end
    end

    // Bit gi belongs to the field when it lies below the captured length.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign mask[gi] = (5'(gi) < flen_q);
    end
`else
    // Full-word only. The len port exists for pin compatibility and has no
    // effect here.
    logic unused_len;
    assign unused_len = ^len;
    assign eff_len    = FULL_LEN;
    assign mask       = '1;
`endif

    // The current LSB of the source enters at the bottom of the accumulator.
    // After L shifts, source bit 0 has moved up to position L-1.
    assign acc_shift = {acc_q[WIDTH-2:0], src_q[0]};

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        src_d   = src_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hold_d  = In;
                    src_d   = In;
                    acc_d   = '0;
                    cnt_d   = eff_len;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                acc_d = acc_shift;
                src_d = src_q >> 1;
                cnt_d = cnt_q - 5'd1;
                // The last shift merges straight from acc_shift. That way the
                // result lands on the same edge as that shift, not one later.
                if (cnt_q == 5'd1) begin
                    out_d   = (hold_q & ~mask) | (acc_shift & mask);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            src_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            src_q   <= src_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // done is registered and the FSM is back in IDLE by the time done is
    // high. So busy and done can never be high together.
    assign busy = (state_q == S_SHIFT);
    assign done = done_q;
    assign Out  = out_q;

endmodule

// File: tb/tb_btr_serial.sv
// -----------------------------------------------------------------------------
// tb_btr_serial
//
// Scoreboard bench for btr_serial. Each accepted request pushes three values
// into a queue: its expected result, the cycle its done pulse should appear,
// and its busy length. A separate monitor pops one entry whenever done is
// seen and compares it. Expected results come from a direct bit-index
// reversal of the low field. It handles the configuration macro in the same
// way as the design.
// -----------------------------------------------------------------------------
module tb_btr_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] In;
    logic [4:0]  len;
    logic [15:0] Out;
    logic        busy;
    logic        done;

    btr_serial #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (In),
        .len   (len),
        .Out   (Out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] out;
        int          due;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    function automatic int eff_len(logic [4:0] l);
        int n;
        n = 16;
`ifdef BTR_SERIAL_FIELD_EN
        if (l != 5'd0 && l <= 5'd16) n = int'(l);
`endif
        return n;
    endfunction

    // Reverse the low L bits by index; upper bits are unchanged.
    function automatic logic [15:0] model(logic [15:0] din, logic [4:0] l);
        int          n;
        logic [15:0] r;
        n = eff_len(l);
        r = din;
        for (int i = 0; i < n; i++) r[i] = din[n-1-i];
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: pops one expectation for every done pulse.
    int   bcount = 0;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            bcount = 0;
        end else begin
            if (busy) bcount++;
            if (done) begin
                check("busy_during_done", {31'd0, busy}, 32'd0);
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: Out=0x%04h with nothing pending (cycle %0d)", Out, cyc);
                end else begin
                    e = q.pop_front();
                    check("out", {16'd0, Out}, {16'd0, e.out});
                    check("done_cycle", cyc, e.due);
                    check("busy_cycles", bcount, e.lat);
                    $display("op done: Out=0x%04h expected=0x%04h cycle=%0d busy=%0d", Out, e.out, cyc, bcount);
                end
                bcount = 0;
            end
        end
    end

    // Call at a falling edge. Returns at the falling edge after acceptance.
    task automatic start_op(logic [15:0] din, logic [4:0] l);
        exp_t x;
        In    = din;
        len   = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        x.out = model(din, l);
        x.lat = eff_len(l);
        x.due = cyc + x.lat;
        q.push_back(x);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        In    = 16'($urandom);
        len   = 5'($urandom);
    endtask

    // Returns at the falling edge where done is high.
    task automatic wait_done();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) return;
        end
        checks++;
        $display("FAIL done_timeout: no done within 40 cycles (cycle %0d)", cyc);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        In    = '0;
        len   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_out", {16'd0, Out}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_out", {16'd0, Out}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
        end

        // Full-word reversals.
        start_op(16'h0001, 5'd0);
        wait_done();
        @(negedge clk);
        start_op(16'hA5C3, 5'd0);
        wait_done();
        @(negedge clk);

        // Field reverse and its inverse. Without the macro these are full reverses.
        start_op(16'h1238, 5'd4);
        wait_done();
        @(negedge clk);
        start_op(16'h1231, 5'd4);
        wait_done();
        @(negedge clk);

        // A start during SHIFT is ignored. A start during the done cycle is accepted.
        start_op(16'h0001, 5'd0);
        repeat (3) @(negedge clk);
        In    = 16'hFFFF;
        len   = 5'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start_op(16'hA5C3, 5'd0);
        wait_done();
        @(negedge clk);

        // Abort with reset partway through an operation.
        start_op(16'hBEEF, 5'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out", {16'd0, Out}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (20) @(negedge clk);
        start_op(16'h00F0, 5'd8);
        wait_done();
        @(negedge clk);

        // Random operations with random gaps, including back-to-back starts.
        for (int t = 0; t < 25; t++) begin
            start_op(16'($urandom), 5'($urandom_range(0, 31)));
            wait_done();
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/btr_serial.md
# btr_serial

Multi-cycle bit-reverse coprocessor for the single-cycle datapath. It takes a 16-bit word plus a field length and rebuilds the word with the low `len` bits in reversed order, one bit per clock. It is the undo and field-limited counterpart of the combinational full-word bit reverser: applying it to a reversed field restores the original. It sits beside the ALU, starts on a one-cycle `start` strobe, and reports completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 16, data word width (the datapath fixes it at 16; `len` width is 5).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request strobe; sampled only in IDLE.
- `In` in WIDTH: operand; captured on accepted `start`.
- `len` in 5: field length 1..16; value 0 means 16; values above 16 are clamped to 16. Captured on accepted `start`.
- `Out` out WIDTH: result register; holds its value between operations.
- `busy` out 1: high while shifting.
- `done` out 1: one-cycle pulse when `Out` is updated.

## Operation
- Reset sets `Out`=0, `busy`=0, `done`=0, state IDLE, and clears all internal registers.
- States and transitions:
  - IDLE: when `start`=1, capture `In` into `hold` and `src`, clear `acc`, load `cnt` with the effective length, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, `acc <= {acc[WIDTH-2:0], src[0]}`, `src <= src >> 1`, `cnt <= cnt-1`.
  - On the shift where `cnt`=1, that shift completes and the block loads the merge, pulses `done`, and returns to IDLE.
- Merge: `mask` = low effective-length bits set to 1. `Out <= (hold & ~mask) | (acc_next & mask)`, so bits above the field pass through unchanged.
- `start` is ignored in SHIFT; no queuing.
- `In` and `len` may change freely after capture.
- `rst` asserted during SHIFT aborts the operation: no `done`, and `Out` resets to 0.
- `start` in the IDLE cycle where `done`=1 is accepted, giving back-to-back operation.

## Timing
- `start` sampled at edge k, with effective length L:
  - `busy`=1 from after edge k through edge k+L.
  - Shifts occur at edges k+1 .. k+L.
  - `Out` and `done` update at edge k+L, so `done` is high for exactly the cycle after edge k+L.
- Latency is L cycles from the accepting edge to valid `Out`: 16 for a full word, 1 minimum.
- `Out` is stable from edge k+L until the next completion or reset; it keeps the previous result during SHIFT.
- `busy` and `done` are never high in the same cycle.

## Configuration
- `BTR_SERIAL_FIELD_EN` defined: the `len` port is honoured as described above.
- Not defined: `len` is ignored (the port remains and is unconnected internally). Effective length is always WIDTH, latency is always 16, and `mask` is all ones.

## Test plan
- Reset then idle: `Out`=0x0000, `busy`=0, `done`=0. Hold `start`=0 for 5 cycles and no change occurs.
- `In`=0x0001, `len`=0, pulse `start` → `busy` high for 16 cycles, then `done` pulses once with `Out`=0x8000. Repeat with `In`=0xA5C3 → `Out`=0xC3A5.
- Field reverse, macro defined: `In`=0x1238, `len`=4 → `done` 4 cycles after acceptance with `Out`=0x1231. Feed 0x1231 back with `len`=4 → `Out`=0x1238.
- `start` re-asserted mid-SHIFT with different `In` → ignored; the original result and timing are unchanged. Then `start` during the `done` cycle → accepted, and the second result arrives L cycles later.
- `rst` pulsed 5 cycles into a 16-bit operation → `busy`=0, `Out`=0, no `done` pulse, state IDLE. The next `start` completes normally.
- Macro undefined: `In`=0x1238, `len`=4 → latency 16, `Out`=0x1C48 (full reverse).
